// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Iterative sequencer for a 128-bit T-table AES round datapath.
//   - Applies round-0 key whitening on accept.
//   - Loops the state NR times through the external table + column-combine
//     logic, waiting TBL_LAT cycles per round for the table result.
//   - Returns the ciphertext on a valid/ready handshake.
//
//   Optional feature macro: AES_CTRL_ABORT_EN
//     When defined, an 'abort' input discards the block in flight and
//     returns the sequencer to IDLE on the next edge.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TBL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [127:0] din,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] tbl_state,
  output logic         tbl_final,
  input  logic [127:0] round_result,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
`ifdef AES_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam int LW = $clog2(TBL_LAT + 1);
  localparam logic [3:0]    NR_C       = 4'(NR);
  localparam logic [LW-1:0] LAT_RELOAD = LW'(TBL_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic [3:0]    round_q,      round_d;
  logic [LW-1:0] lat_q,        lat_d;
  logic [127:0]  tbl_state_q,  tbl_state_d;
  logic          tbl_final_q,  tbl_final_d;
  logic [127:0]  dout_q,       dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          ready_q,      ready_d;
  logic          busy_q,       busy_d;
  logic          abort_s;

  // Abort request, only meaningful when the feature is built in.
  always_comb begin
`ifdef AES_CTRL_ABORT_EN
    abort_s = abort;
`else
    abort_s = 1'b0;
`endif
  end

  // Next-state logic: sequencing, round/latency counters, datapath capture.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    lat_d        = lat_q;
    tbl_state_d  = tbl_state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    case (state_q)
      ST_IDLE: begin
        // Round counter doubles as the key index, so key 0 is presented here.
        round_d = 4'd0;
        if (start) begin
          tbl_state_d = din ^ rk_data;
          round_d     = 4'd1;
          lat_d       = LAT_RELOAD;
          state_d     = ST_ROUND;
        end else begin
          lat_d = {LW{1'b0}};
        end
      end

      ST_ROUND: begin
        if (lat_q != {LW{1'b0}}) begin
          lat_d = lat_q - {{(LW-1){1'b0}}, 1'b1};
        end else if (round_q < NR_C) begin
          tbl_state_d = round_result;
          round_d     = round_q + 4'd1;
          lat_d       = LAT_RELOAD;
        end else begin
          dout_d       = round_result;
          dout_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        if (dout_valid_q && dout_ready) begin
          dout_valid_d = 1'b0;
          round_d      = 4'd0;
          state_d      = ST_IDLE;
        end else begin
          dout_valid_d = dout_valid_q;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        round_d      = 4'd0;
        lat_d        = {LW{1'b0}};
        dout_valid_d = 1'b0;
      end
    endcase

    // Abort outranks every other transition, including the DONE handshake.
    if (abort_s && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      round_d      = 4'd0;
      lat_d        = {LW{1'b0}};
      dout_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Status outputs are registered from the upcoming state.
    tbl_final_d = (state_d == ST_ROUND) && (round_d == NR_C);
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; async reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_q      <= 4'd0;
      lat_q        <= {LW{1'b0}};
      tbl_state_q  <= 128'd0;
      tbl_final_q  <= 1'b0;
      dout_q       <= 128'd0;
      dout_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      lat_q        <= lat_d;
      tbl_state_q  <= tbl_state_d;
      tbl_final_q  <= tbl_final_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign rk_idx     = round_q;
  assign tbl_state  = tbl_state_q;
  assign tbl_final  = tbl_final_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
